// File: rtl/ifetch_queue_if.sv
// Fetch front-end bundle: ibus request/response, redirect input and the
// decode-side head-of-queue view. The fetch queue is the master side.
interface ifetch_queue_if #(
    parameter int XLEN = 64
);
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [31:0]     iresp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_ready;
    logic [15:0]     drop_cnt;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr,
        input  out_ready,
        output drop_cnt
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr,
        output out_ready,
        input  drop_cnt
    );
endinterface

// File: rtl/ifetch_queue.sv
// Decoupled instruction fetch front-end: owns the fetch PC, drives a
// single-outstanding ibus and buffers {pc, instr} pairs in a small FIFO
// ahead of decode. Redirects flush the FIFO; a request already on the bus
// is held until its response and that response is then discarded.
module ifetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic            r_req_v;
    logic [XLEN-1:0] r_req_a;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_discard;
    logic [15:0]     r_drop_cnt;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];

    logic            w_resp;
    logic            w_redir;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_issue;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [CNT_W-1:0] w_count_next;

    // Per-cycle decisions: response acceptance, push/pop, next count and PC.
    always_comb begin
        w_resp     = r_req_v & bus.iresp_data_ok;
        w_redir    = bus.redirect_valid;
        w_push     = w_resp & ~r_discard & ~w_redir;
        w_pop      = (r_count != {CNT_W{1'b0}}) & bus.out_ready & ~w_redir;
        w_drop     = w_resp & (r_discard | w_redir);
        w_issue    = ~r_req_v | w_resp;
        w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

        if (w_redir) begin
            w_count_next = {CNT_W{1'b0}};
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end

        if (w_redir) begin
            w_fetch_pc_next = w_redir_pc;
        end else if (w_push) begin
            w_fetch_pc_next = r_req_a + XLEN'(4);
        end else begin
            w_fetch_pc_next = r_fetch_pc;
        end
    end

    // Control state: ibus request registers, fetch PC, FIFO pointers, discard and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_v    <= 1'b0;
            r_req_a    <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
            r_drop_cnt <= 16'h0000;
            r_head     <= {PTR_W{1'b0}};
            r_tail     <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
        end else begin
            // A new request is issued only when a slot is reserved for its response.
            if (w_issue) begin
                r_req_v <= (w_count_next < CNT_W'(DEPTH));
                r_req_a <= w_fetch_pc_next;
            end else begin
                r_req_v <= r_req_v;
                r_req_a <= r_req_a;
            end

            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;

            if (w_redir) begin
                r_head <= {PTR_W{1'b0}};
                r_tail <= {PTR_W{1'b0}};
            end else begin
                r_head <= w_pop  ? r_head + PTR_W'(1) : r_head;
                r_tail <= w_push ? r_tail + PTR_W'(1) : r_tail;
            end

            // An in-flight request left behind by a redirect must have its response dropped.
            if (w_redir) begin
                r_discard <= r_req_v & ~bus.iresp_data_ok;
            end else if (w_resp) begin
                r_discard <= 1'b0;
            end else begin
                r_discard <= r_discard;
            end

            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    // FIFO storage write; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]    <= r_req_a;
            r_mem_instr[r_tail] <= bus.iresp_data;
        end
    end

    assign bus.ireq_valid = r_req_v;
    assign bus.ireq_addr  = r_req_a;
    assign bus.out_valid  = (r_count != {CNT_W{1'b0}});
    assign bus.out_pc     = r_mem_pc[r_head];
    assign bus.out_instr  = r_mem_instr[r_head];
    assign bus.drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4): sequential fetch, back-pressure,
// full-queue push/pop, redirects with dropped responses, mid-request reset.
module tb_ifetch_queue;
    localparam logic [63:0] B = 64'h8000_0000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ifetch_queue_if #(.XLEN(64)) u_if ();

    ifetch_queue #(.DEPTH(4), .XLEN(64), .RESET_PC(64'h8000_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        u_if.iresp_data_ok  = 1'b0;
        u_if.iresp_data     = 32'h0;
        u_if.redirect_valid = 1'b0;
        u_if.redirect_pc    = 64'h0;
        u_if.out_ready      = 1'b0;
        tick();
        tick();
        chk("rst_ireq_valid", {63'd0, u_if.ireq_valid}, 64'd0);
        chk("rst_out_valid",  {63'd0, u_if.out_valid},  64'd0);
        chk("rst_drop_cnt",   {48'd0, u_if.drop_cnt},   64'd0);

        reset = 1'b0;
        tick();
        chk("first_req_valid", {63'd0, u_if.ireq_valid}, 64'd1);
        chk("first_req_addr",  u_if.ireq_addr, B);

        // Sequential fetch with zero-latency memory and decode always ready.
        u_if.out_ready = 1'b1;
        u_if.iresp_data_ok = 1'b1;
        u_if.iresp_data = 32'hC000_0000;
        tick();
        chk("t1_addr1",  u_if.ireq_addr, B + 64'h4);
        chk("t1_ovalid", {63'd0, u_if.out_valid}, 64'd1);
        chk("t1_opc0",   u_if.out_pc, B);
        chk("t1_oins0",  {32'd0, u_if.out_instr}, 64'hC000_0000);
        u_if.iresp_data = 32'hC000_0004;
        tick();
        chk("t1_addr2",  u_if.ireq_addr, B + 64'h8);
        chk("t1_opc1",   u_if.out_pc, B + 64'h4);
        chk("t1_oins1",  {32'd0, u_if.out_instr}, 64'hC000_0004);
        u_if.iresp_data = 32'hC000_0008;
        tick();
        chk("t1_addr3",  u_if.ireq_addr, B + 64'hC);
        chk("t1_opc2",   u_if.out_pc, B + 64'h8);
        u_if.iresp_data_ok = 1'b0;
        tick();
        chk("t1_empty",  {63'd0, u_if.out_valid}, 64'd0);
        chk("t1_hold_v", {63'd0, u_if.ireq_valid}, 64'd1);
        chk("t1_hold_a", u_if.ireq_addr, B + 64'hC);

        // Decode stalled: exactly DEPTH pushes, then requests stop.
        u_if.out_ready = 1'b0;
        u_if.iresp_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            u_if.iresp_data = 32'hC000_000C + 32'(4 * k);
            tick();
            chk("t2_req_valid", {63'd0, u_if.ireq_valid}, (k < 3) ? 64'd1 : 64'd0);
        end
        chk("t2_head_pc",   u_if.out_pc, B + 64'hC);
        chk("t2_head_ins",  {32'd0, u_if.out_instr}, 64'hC000_000C);
        tick();
        chk("t2_still_off", {63'd0, u_if.ireq_valid}, 64'd0);
        chk("t2_no_ovf_pc", u_if.out_pc, B + 64'hC);
        u_if.out_ready = 1'b1;
        u_if.iresp_data_ok = 1'b0;
        tick();
        chk("t2_resume_v",  {63'd0, u_if.ireq_valid}, 64'd1);
        chk("t2_resume_a",  u_if.ireq_addr, B + 64'h1C);
        chk("t2_head2",     u_if.out_pc, B + 64'h10);

        // Simultaneous pop and push near full, then fill and drain across the wrap.
        u_if.iresp_data_ok = 1'b1;
        u_if.iresp_data = 32'hC000_001C;
        tick();
        chk("t5_pp_head",   u_if.out_pc, B + 64'h14);
        chk("t5_pp_addr",   u_if.ireq_addr, B + 64'h20);
        chk("t5_pp_valid",  {63'd0, u_if.ireq_valid}, 64'd1);
        u_if.out_ready = 1'b0;
        u_if.iresp_data = 32'hC000_0020;
        tick();
        chk("t5_full_off",  {63'd0, u_if.ireq_valid}, 64'd0);
        chk("t5_full_head", u_if.out_pc, B + 64'h14);
        u_if.iresp_data_ok = 1'b0;
        u_if.out_ready = 1'b1;
        tick();
        chk("t5_d1_pc",     u_if.out_pc, B + 64'h18);
        chk("t5_d1_addr",   u_if.ireq_addr, B + 64'h24);
        tick();
        chk("t5_d2_pc",     u_if.out_pc, B + 64'h1C);
        chk("t5_d2_ins",    {32'd0, u_if.out_instr}, 64'hC000_001C);
        tick();
        chk("t5_d3_pc",     u_if.out_pc, B + 64'h20);
        chk("t5_d3_ins",    {32'd0, u_if.out_instr}, 64'hC000_0020);
        tick();
        chk("t5_d4_empty",  {63'd0, u_if.out_valid}, 64'd0);
        chk("t5_d4_hold",   u_if.ireq_addr, B + 64'h24);

        // Redirect while a request waits; low PC bits are ignored.
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc = 64'h8000_0103;
        tick();
        u_if.redirect_valid = 1'b0;
        chk("t3_flush",     {63'd0, u_if.out_valid}, 64'd0);
        chk("t3_hold_v",    {63'd0, u_if.ireq_valid}, 64'd1);
        chk("t3_hold_a1",   u_if.ireq_addr, B + 64'h24);
        tick();
        chk("t3_hold_a2",   u_if.ireq_addr, B + 64'h24);
        chk("t3_no_drop",   {48'd0, u_if.drop_cnt}, 64'd0);
        u_if.iresp_data_ok = 1'b1;
        u_if.iresp_data = 32'hDEAD_BEEF;
        tick();
        chk("t3_new_addr",  u_if.ireq_addr, B + 64'h100);
        chk("t3_drop1",     {48'd0, u_if.drop_cnt}, 64'd1);
        chk("t3_not_out",   {63'd0, u_if.out_valid}, 64'd0);

        // Redirect coinciding with data_ok and a pop.
        u_if.iresp_data = 32'hC000_0100;
        tick();
        chk("t4_pre_pc",    u_if.out_pc, B + 64'h100);
        chk("t4_pre_addr",  u_if.ireq_addr, B + 64'h104);
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc = B + 64'h200;
        tick();
        u_if.redirect_valid = 1'b0;
        chk("t4_empty",     {63'd0, u_if.out_valid}, 64'd0);
        chk("t4_addr",      u_if.ireq_addr, B + 64'h200);
        chk("t4_valid",     {63'd0, u_if.ireq_valid}, 64'd1);
        chk("t4_drop2",     {48'd0, u_if.drop_cnt}, 64'd2);
        u_if.iresp_data = 32'hC000_0200;
        tick();
        chk("t4_out_pc",    u_if.out_pc, B + 64'h200);
        chk("t4_out_ins",   {32'd0, u_if.out_instr}, 64'hC000_0200);
        chk("t4_next_addr", u_if.ireq_addr, B + 64'h204);

        // Repeated redirects while discarding: last target wins, one drop.
        u_if.iresp_data_ok = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc = B + 64'h300;
        tick();
        chk("rr_flush",     {63'd0, u_if.out_valid}, 64'd0);
        chk("rr_hold",      u_if.ireq_addr, B + 64'h204);
        u_if.redirect_pc = B + 64'h400;
        tick();
        u_if.redirect_valid = 1'b0;
        u_if.iresp_data_ok = 1'b1;
        tick();
        chk("rr_drop3",     {48'd0, u_if.drop_cnt}, 64'd3);
        chk("rr_addr",      u_if.ireq_addr, B + 64'h400);

        // Reset in the middle of an outstanding request.
        u_if.iresp_data = 32'hC000_0400;
        tick();
        chk("t6_pre_valid", {63'd0, u_if.out_valid}, 64'd1);
        chk("t6_pre_addr",  u_if.ireq_addr, B + 64'h404);
        reset = 1'b1;
        tick();
        chk("t6_rst_req",   {63'd0, u_if.ireq_valid}, 64'd0);
        chk("t6_rst_out",   {63'd0, u_if.out_valid}, 64'd0);
        chk("t6_rst_drop",  {48'd0, u_if.drop_cnt}, 64'd0);
        reset = 1'b0;
        u_if.iresp_data_ok = 1'b0;
        tick();
        chk("t6_req_v",     {63'd0, u_if.ireq_valid}, 64'd1);
        chk("t6_req_a",     u_if.ireq_addr, B);
        chk("t6_out_empty", {63'd0, u_if.out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
